mux4_rr_arbiter: RTL

- Round-robin arbiter that shares one 4-to-1 datapath mux (mux_4x1) between four requesters.
- Drives the mux select s[1:0] from the current owner and issues a one-hot grant.
- Holds ownership until the owner releases or a hold timeout preempts it.
- Sits beside mux_4x1 at the next level up; the parent connects sel to the mux s input.

---
 rtl/mux_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 31 +++
 rtl/mux4_rr_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the four-way round-robin mux arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first masked request at or after ptr, wrapping mod 4.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0] mreq;
  logic [SEL_W-1:0] cand;

  assign mreq = req & mask;

  // Walk from the farthest candidate back to ptr so the nearest hit is the last one written.
  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (mreq[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 mux; sel drives the mux select, grant is one-hot ownership.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             preempt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             preempt_q, preempt_d;

  logic             owner_req;
  logic             others;
  logic             timeout;
  logic [N_REQ-1:0] pick_mask;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;

  assign owner_req = req[sel_q];
  assign others    = |(req & ~onehot(sel_q));
  assign timeout   = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

  // A timed-out owner still requesting must not win its own handover.
  assign pick_mask = (state_q == GRANT && owner_req && timeout) ? ~onehot(sel_q) : '1;

  rr_pick u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .mask (pick_mask),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  always_comb begin
    logic take;
    take      = 1'b0;
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) take = 1'b1;
      end
      GRANT: begin
        if (!owner_req) begin
          if (others) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (timeout) begin
          // Alone at the limit: keep the grant and leave the counter saturated.
          if (others) begin
            take      = 1'b1;
            preempt_d = 1'b1;
          end
        end else if (hold_q != '1) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    if (take) begin
      state_d = GRANT;
      grant_d = onehot(pick_idx);
      sel_d   = pick_idx;
      ptr_d   = pick_idx + SEL_W'(1);
      hold_d  = '0;
    end
  end

  always_comb begin
    grant   = grant_q;
    sel     = sel_q;
    valid   = (state_q == GRANT);
    preempt = preempt_q;
  end

endmodule
